fir_tap_arbiter: RTL

- Arbitrates the single-port tap-coefficient BRAM between two requesters.
  - Host: the AXI-Lite configuration path, which reads and writes coefficients.
  - Engine: the FIR MAC datapath, which fetches coefficients once per tap.
- Fixed priority to the engine, with a starvation guard so host reads still complete while the engine streams.
- Returns 1-cycle-latency read data to whichever requester was granted, and blocks coefficient writes while the engine is busy.

---
 rtl/fir_pkg.sv | 14 +
 rtl/fir_starve_guard.sv | 30 +++
 rtl/fir_tap_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the tap-coefficient BRAM arbiter.
package fir_pkg;

  typedef enum logic [1:0] {
    RTAG_NONE      = 2'd0,
    RTAG_ENG       = 2'd1,
    RTAG_HOST      = 2'd2,
    RTAG_HOST_ZERO = 2'd3
  } rtag_t;

  localparam int         TAP_STRIDE = 4;
  localparam logic [3:0] WE_ALL     = 4'hF;

endpackage

// File: rtl/fir_starve_guard.sv
// Host starvation guard: counts consecutive denied host cycles (saturating)
// and raises o_force once the host has waited pMAX_WAIT cycles.
module fir_starve_guard #(
  parameter int pMAX_WAIT = 4
) (
  input  logic axis_clk,
  input  logic axis_rst_n,
  input  logic i_h_req,
  input  logic i_h_gnt,
  output logic o_force
);

  localparam int CW = (pMAX_WAIT < 1) ? 1 : $clog2(pMAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(pMAX_WAIT);

  logic [CW-1:0] r_wait_cnt;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_wait_cnt <= '0;
    end else if (i_h_gnt) begin
      r_wait_cnt <= '0;
    end else if (i_h_req && (r_wait_cnt != MAX_CNT)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign o_force = i_h_req && (r_wait_cnt == MAX_CNT);

endmodule

// File: rtl/fir_tap_arbiter.sv
// Single-port tap BRAM arbiter: engine-priority with host starvation guard.
// Optional perf counters are built when FIR_TAP_ARB_PERF_EN is defined.
module fir_tap_arbiter
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int pMAX_WAIT   = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   h_req,
  input  logic                   h_we,
  input  logic [pADDR_WIDTH-1:0] h_addr,
  input  logic [pDATA_WIDTH-1:0] h_wdata,
  output logic                   h_gnt,
  output logic                   h_rvalid,
  output logic [pDATA_WIDTH-1:0] h_rdata,
  output logic                   h_werr,
  input  logic                   e_req,
  input  logic [pADDR_WIDTH-1:0] e_addr,
  output logic                   e_gnt,
  output logic                   e_rvalid,
  output logic [pDATA_WIDTH-1:0] e_rdata,
  input  logic                   cfg_lock,
`ifdef FIR_TAP_ARB_PERF_EN
  output logic [15:0]            perf_h_stall,
  output logic [7:0]             perf_h_force,
`endif
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do
);

  localparam logic [pADDR_WIDTH-1:0] ADDR_LIM  = pADDR_WIDTH'(TAP_STRIDE * Tape_Num);
  localparam logic [pADDR_WIDTH-1:0] ADDR_MASK = ~pADDR_WIDTH'(TAP_STRIDE - 1);

  logic                   w_force;
  logic                   w_h_win;
  logic                   w_h_in_range;
  logic [pADDR_WIDTH-1:0] w_addr;
  rtag_t                  r_rtag;
  logic                   r_werr;
  logic [pDATA_WIDTH-1:0] r_h_hold;
  logic [pDATA_WIDTH-1:0] r_e_hold;

  fir_starve_guard #(.pMAX_WAIT(pMAX_WAIT)) u_guard (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .i_h_req    (h_req),
    .i_h_gnt    (h_gnt),
    .o_force    (w_force)
  );

  // Grants are gated by reset so the BRAM is never touched while in reset.
  assign w_h_win      = h_req && (!e_req || w_force);
  assign h_gnt        = axis_rst_n && w_h_win;
  assign e_gnt        = axis_rst_n && e_req && !w_h_win;
  assign w_h_in_range = (h_addr < ADDR_LIM);

  assign w_addr = h_gnt ? h_addr : e_addr;
  assign tap_A  = w_addr & ADDR_MASK;
  assign tap_Di = h_wdata;
  assign tap_EN = e_gnt || (h_gnt && w_h_in_range);
  assign tap_WE = (h_gnt && h_we && w_h_in_range && !cfg_lock) ? WE_ALL : 4'h0;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_rtag   <= RTAG_NONE;
      r_werr   <= 1'b0;
      r_h_hold <= '0;
      r_e_hold <= '0;
    end else begin
      r_werr <= h_gnt && h_we && cfg_lock;
      if (e_gnt)
        r_rtag <= RTAG_ENG;
      else if (h_gnt && !h_we)
        r_rtag <= w_h_in_range ? RTAG_HOST : RTAG_HOST_ZERO;
      else
        r_rtag <= RTAG_NONE;
      if (r_rtag == RTAG_HOST)
        r_h_hold <= tap_Do;
      else if (r_rtag == RTAG_HOST_ZERO)
        r_h_hold <= '0;
      if (r_rtag == RTAG_ENG)
        r_e_hold <= tap_Do;
    end
  end

  // BRAM data is live in the return cycle; the hold registers keep it afterwards.
  assign h_rvalid = (r_rtag == RTAG_HOST) || (r_rtag == RTAG_HOST_ZERO);
  assign e_rvalid = (r_rtag == RTAG_ENG);
  assign h_rdata  = (r_rtag == RTAG_HOST) ? tap_Do :
                    (r_rtag == RTAG_HOST_ZERO) ? '0 : r_h_hold;
  assign e_rdata  = (r_rtag == RTAG_ENG) ? tap_Do : r_e_hold;
  assign h_werr   = r_werr;

`ifdef FIR_TAP_ARB_PERF_EN
  logic [15:0] r_perf_stall;
  logic [7:0]  r_perf_force;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_perf_stall <= '0;
      r_perf_force <= '0;
    end else begin
      if (h_req && !h_gnt && (r_perf_stall != 16'hFFFF))
        r_perf_stall <= r_perf_stall + 16'd1;
      if (w_force && (r_perf_force != 8'hFF))
        r_perf_force <= r_perf_force + 8'd1;
    end
  end

  assign perf_h_stall = r_perf_stall;
  assign perf_h_force = r_perf_force;
`endif

endmodule
